// File: rtl/microwave_ctrl_gen.sv
// Microwave controller: keypad entry, BCD MM:SS countdown,
// power duty cycling, door interlock and end-of-cook beep.
module microwave_ctrl_gen #(
    parameter int CLK_DIV    = 100,
    parameter int DEBOUNCE   = 4,
    parameter int MIN_DIGITS = 1,
    parameter int BEEP_SEC   = 3
) (
    input  logic                    clk,
    input  logic                    clear,
    input  logic [9:0]              keys,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    cancel,
    input  logic                    power_key,
    input  logic                    door_closed,
    output logic [4*MIN_DIGITS-1:0] minutes,
    output logic [3:0]              tens_sec,
    output logic [3:0]              units_sec,
    output logic [3:0]              power,
    output logic                    magnetron,
    output logic                    beep,
    output logic [2:0]              state
);

    localparam int NDIG = MIN_DIGITS + 2;
    localparam int PW   = $clog2(CLK_DIV);
    localparam int DW   = $clog2(DEBOUNCE + 1);

    localparam logic [PW-1:0] PS_MAX    = PW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE);
    localparam logic [3:0]    BEEP_LAST = 4'(BEEP_SEC - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SET   = 3'd1;
    localparam logic [2:0] S_COOK  = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // dig[0] = units, dig[1] = tens, dig[2..] = minutes (lsd first)
    logic [NDIG-1:0][3:0] dig;
    logic [NDIG-1:0][3:0] dig_dec;
    logic [NDIG-1:0][3:0] dig_shift;
    logic                 borrow;

    logic [PW-1:0] presc;
    logic [3:0]    phase;
    logic [3:0]    beep_cnt;

    logic [9:0]    key_q;
    logic [DW-1:0] db_cnt;
    logic          key_lock;
    logic [3:0]    key_digit;

    logic start_q, stop_q, cancel_q, pkey_q;
    logic start_e, stop_e, cancel_e, pkey_e;
    logic tick, accept, time_zero, dec_zero, door_open;

    assign minutes   = dig[NDIG-1:2];
    assign tens_sec  = dig[1];
    assign units_sec = dig[0];

    assign start_e  = start & ~start_q;
    assign stop_e   = stop & ~stop_q;
    assign cancel_e = cancel & ~cancel_q;
    assign pkey_e   = power_key & ~pkey_q;

    assign door_open = ~door_closed;
    assign tick      = (state == S_COOK || state == S_DONE)
                       && presc == PS_MAX;
    assign accept    = (db_cnt == DB_MAX) && !key_lock
                       && (key_q != '0);
    assign time_zero = (dig == '0);
    assign dec_zero  = (dig_dec == '0);

    assign magnetron = (state == S_COOK) && (phase < power)
                       && door_closed;
    assign beep      = (state == S_DONE);

    always_comb begin
        key_digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (key_q[i]) key_digit = 4'(i);
        end
    end

    // Tens reload to 5 on borrow; every other digit reloads to 9.
    always_comb begin
        dig_dec = dig;
        borrow  = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (borrow) begin
                if (dig[i] == 4'd0) begin
                    dig_dec[i] = (i == 1) ? 4'd5 : 4'd9;
                end else begin
                    dig_dec[i] = dig[i] - 4'd1;
                    borrow     = 1'b0;
                end
            end
        end
    end

    assign dig_shift = {dig[NDIG-2:0], key_digit};

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            cancel_q <= 1'b0;
            pkey_q   <= 1'b0;
            key_q    <= '0;
            db_cnt   <= '0;
            key_lock <= 1'b0;
        end else begin
            start_q  <= start;
            stop_q   <= stop;
            cancel_q <= cancel;
            pkey_q   <= power_key;
            key_q    <= keys;
            if (keys == '0) begin
                db_cnt   <= '0;
                key_lock <= 1'b0;
            end else begin
                if (keys != key_q) begin
                    db_cnt <= DW'(1);
                end else if (db_cnt != DB_MAX) begin
                    db_cnt <= db_cnt + DW'(1);
                end
                if (accept) key_lock <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state    <= S_IDLE;
            dig      <= '0;
            power    <= 4'd10;
            presc    <= '0;
            phase    <= 4'd0;
            beep_cnt <= 4'd0;
        end else begin
            if (state == S_COOK || state == S_DONE) begin
                presc <= tick ? '0 : presc + PW'(1);
            end else begin
                presc <= '0;
            end
            unique case (state)
                S_IDLE, S_SET: begin
                    if (cancel_e) begin
                        state <= S_IDLE;
                        dig   <= '0;
                    end else if (start_e && state == S_SET
                                 && door_closed && !time_zero) begin
                        state <= S_COOK;
                        phase <= 4'd0;
                    end else if (accept) begin
                        dig   <= dig_shift;
                        state <= S_SET;
                    end
                    if (pkey_e) begin
                        power <= (power == 4'd1) ? 4'd10
                                                 : power - 4'd1;
                    end
                end
                S_COOK: begin
                    if (cancel_e) begin
                        state <= S_IDLE;
                        dig   <= '0;
                        power <= 4'd10;
                    end else if (door_open || stop_e) begin
                        state <= S_PAUSE;
                    end else if (tick) begin
                        dig   <= dig_dec;
                        phase <= (phase == 4'd9) ? 4'd0
                                                 : phase + 4'd1;
                        if (dec_zero) begin
                            state    <= S_DONE;
                            beep_cnt <= 4'd0;
                        end
                    end
                end
                S_PAUSE: begin
                    if (cancel_e || stop_e) begin
                        state <= S_IDLE;
                        dig   <= '0;
                    end else if (start_e && door_closed) begin
                        state <= S_COOK;
                    end
                end
                S_DONE: begin
                    if (cancel_e || door_open || stop_e
                        || start_e || accept) begin
                        state <= S_IDLE;
                    end else if (tick) begin
                        if (beep_cnt == BEEP_LAST) begin
                            state <= S_IDLE;
                        end else begin
                            beep_cnt <= beep_cnt + 4'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_microwave_ctrl_gen.sv
// Directed bench for microwave_ctrl_gen with CLK_DIV=4,
// DEBOUNCE=4, MIN_DIGITS=1, BEEP_SEC=3.
module tb_microwave_ctrl_gen;

    localparam int DB = 4;

    logic       clk;
    logic       clear;
    logic [9:0] keys;
    logic       start, stop, cancel, power_key, door_closed;
    logic [3:0] minutes, tens_sec, units_sec, power;
    logic       magnetron, beep;
    logic [2:0] state;
    logic [11:0] tv;

    int checks;
    int failures;

    assign tv = {minutes, tens_sec, units_sec};

    microwave_ctrl_gen #(
        .CLK_DIV(4), .DEBOUNCE(DB), .MIN_DIGITS(1), .BEEP_SEC(3)
    ) dut (
        .clk(clk), .clear(clear), .keys(keys),
        .start(start), .stop(stop), .cancel(cancel),
        .power_key(power_key), .door_closed(door_closed),
        .minutes(minutes), .tens_sec(tens_sec),
        .units_sec(units_sec), .power(power),
        .magnetron(magnetron), .beep(beep), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task press(input int b);
        case (b)
            0: start = 1'b1;
            1: stop = 1'b1;
            2: cancel = 1'b1;
            default: power_key = 1'b1;
        endcase
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        cancel = 1'b0;
        power_key = 1'b0;
    endtask

    task press_key(input int d);
        keys = '0;
        keys[d] = 1'b1;
        repeat (DB + 2) @(negedge clk);
        keys = '0;
        repeat (2) @(negedge clk);
    endtask

    task cancel_all();
        press(2);
        @(negedge clk);
    endtask

    task test_reset();
        clear = 1'b0;
        keys = '0;
        start = 0; stop = 0; cancel = 0; power_key = 0;
        door_closed = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (state !== 3'd0 || tv !== 12'h000 || power !== 4'd10
            || magnetron !== 1'b0 || beep !== 1'b0) begin
            failures++;
            $display("FAIL reset: st=%0d t=%h pw=%0d mag=%b bp=%b expected 0 000 10 0 0",
                     state, tv, power, magnetron, beep);
        end
        clear = 1'b1;
        @(negedge clk);
    endtask

    task test_debounce();
        keys = '0;
        keys[6] = 1'b1;
        repeat (DB) @(negedge clk);
        checks++;
        if (tv !== 12'h000) begin
            failures++;
            $display("FAIL db_early: got %h expected 000", tv);
        end
        @(negedge clk);
        checks++;
        if (tv !== 12'h006 || state !== 3'd1) begin
            failures++;
            $display("FAIL db_accept: got %h st=%0d expected 006 st=1", tv, state);
        end
        keys = '0;
        repeat (2) @(negedge clk);
        cancel_all();
        keys[5] = 1'b1;
        repeat (DB - 1) @(negedge clk);
        keys = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (tv !== 12'h000 || state !== 3'd0) begin
            failures++;
            $display("FAIL db_short: got %h st=%0d expected 000 st=0", tv, state);
        end
        keys[3] = 1'b1;
        repeat (20) @(negedge clk);
        keys = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (tv !== 12'h003) begin
            failures++;
            $display("FAIL db_held_once: got %h expected 003", tv);
        end
        cancel_all();
    endtask

    task test_entry();
        press_key(1);
        checks++;
        if (tv !== 12'h001 || state !== 3'd1) begin
            failures++;
            $display("FAIL entry_1: got %h st=%0d expected 001 st=1", tv, state);
        end
        press_key(3);
        checks++;
        if (tv !== 12'h013) begin
            failures++;
            $display("FAIL entry_13: got %h expected 013", tv);
        end
        press_key(0);
        checks++;
        if (tv !== 12'h130) begin
            failures++;
            $display("FAIL entry_130: got %h expected 130", tv);
        end
        press_key(5);
        checks++;
        if (tv !== 12'h305 || state !== 3'd1) begin
            failures++;
            $display("FAIL entry_305: got %h st=%0d expected 305 st=1", tv, state);
        end
        press(2);
        checks++;
        if (tv !== 12'h000 || state !== 3'd0) begin
            failures++;
            $display("FAIL entry_cancel: got %h st=%0d expected 000 st=0", tv, state);
        end
        @(negedge clk);
    endtask

    task test_countdown();
        press_key(1);
        press_key(0);
        press_key(0);
        press(0);
        checks++;
        if (state !== 3'd2 || magnetron !== 1'b1) begin
            failures++;
            $display("FAIL cd_start: st=%0d mag=%b expected 2 1", state, magnetron);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (tv !== 12'h100) begin
            failures++;
            $display("FAIL cd_pre_tick: got %h expected 100", tv);
        end
        @(negedge clk);
        checks++;
        if (tv !== 12'h059) begin
            failures++;
            $display("FAIL cd_059: got %h expected 059", tv);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (tv !== 12'h058) begin
            failures++;
            $display("FAIL cd_058: got %h expected 058", tv);
        end
        repeat (231) @(negedge clk);
        checks++;
        if (tv !== 12'h001 || state !== 3'd2) begin
            failures++;
            $display("FAIL cd_001: got %h st=%0d expected 001 st=2", tv, state);
        end
        @(negedge clk);
        checks++;
        if (tv !== 12'h000 || state !== 3'd4 || beep !== 1'b1) begin
            failures++;
            $display("FAIL cd_done: got %h st=%0d bp=%b expected 000 4 1", tv, state, beep);
        end
        repeat (11) @(negedge clk);
        checks++;
        if (state !== 3'd4 || beep !== 1'b1) begin
            failures++;
            $display("FAIL beep_hold: st=%0d bp=%b expected 4 1", state, beep);
        end
        @(negedge clk);
        checks++;
        if (state !== 3'd0 || beep !== 1'b0) begin
            failures++;
            $display("FAIL beep_end: st=%0d bp=%b expected 0 0", state, beep);
        end
        @(negedge clk);
    endtask

    task test_tens_over_five();
        press_key(9);
        press_key(0);
        checks++;
        if (tv !== 12'h090) begin
            failures++;
            $display("FAIL entry_090: got %h expected 090", tv);
        end
        press(0);
        repeat (4) @(negedge clk);
        checks++;
        if (tv !== 12'h089) begin
            failures++;
            $display("FAIL cd_089: got %h expected 089", tv);
        end
        cancel_all();
    endtask

    task test_door();
        press_key(4);
        press_key(5);
        press(0);
        repeat (12) @(negedge clk);
        checks++;
        if (tv !== 12'h042 || magnetron !== 1'b1) begin
            failures++;
            $display("FAIL door_042: got %h mag=%b expected 042 1", tv, magnetron);
        end
        door_closed = 1'b0;
        #1;
        checks++;
        if (magnetron !== 1'b0) begin
            failures++;
            $display("FAIL door_mag_comb: got %b expected 0", magnetron);
        end
        @(negedge clk);
        repeat (8) @(negedge clk);
        checks++;
        if (state !== 3'd3 || tv !== 12'h042) begin
            failures++;
            $display("FAIL door_paused: st=%0d t=%h expected 3 042", state, tv);
        end
        door_closed = 1'b1;
        press(0);
        checks++;
        if (state !== 3'd2) begin
            failures++;
            $display("FAIL door_resume: st=%0d expected 2", state);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (tv !== 12'h042) begin
            failures++;
            $display("FAIL door_resume_hold: got %h expected 042", tv);
        end
        @(negedge clk);
        checks++;
        if (tv !== 12'h041) begin
            failures++;
            $display("FAIL door_041: got %h expected 041", tv);
        end
        cancel_all();
    endtask

    task test_power_duty();
        for (int i = 0; i < 3; i++) begin
            press(3);
            @(negedge clk);
        end
        checks++;
        if (power !== 4'd7) begin
            failures++;
            $display("FAIL power_7: got %0d expected 7", power);
        end
        press_key(2);
        press_key(0);
        press(0);
        for (int t = 0; t < 20; t++) begin
            checks++;
            if (magnetron !== ((t % 10) < 7)) begin
                failures++;
                $display("FAIL duty_t%0d: got %b expected %b", t, magnetron, (t % 10) < 7);
            end
            if (t == 10) begin
                checks++;
                if (tv !== 12'h010) begin
                    failures++;
                    $display("FAIL duty_010: got %h expected 010", tv);
                end
            end
            repeat (4) @(negedge clk);
        end
        checks++;
        if (tv !== 12'h000 || state !== 3'd4) begin
            failures++;
            $display("FAIL duty_done: got %h st=%0d expected 000 4", tv, state);
        end
        cancel_all();
    endtask

    task test_priority();
        press_key(3);
        press_key(0);
        press(0);
        repeat (2) @(negedge clk);
        cancel = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        stop = 1'b0;
        checks++;
        if (state !== 3'd0 || tv !== 12'h000 || power !== 4'd10) begin
            failures++;
            $display("FAIL prio_cancel: st=%0d t=%h pw=%0d expected 0 000 10", state, tv, power);
        end
        @(negedge clk);
        press(0);
        @(negedge clk);
        checks++;
        if (state !== 3'd0) begin
            failures++;
            $display("FAIL start_zero: st=%0d expected 0", state);
        end
        keys = '0;
        keys[2] = 1'b1;
        keys[7] = 1'b1;
        repeat (DB + 2) @(negedge clk);
        keys = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (tv !== 12'h007 || state !== 3'd1) begin
            failures++;
            $display("FAIL multi_key: got %h st=%0d expected 007 1", tv, state);
        end
        cancel_all();
    endtask

    task test_async_reset();
        for (int i = 0; i < 5; i++) begin
            press(3);
            @(negedge clk);
        end
        press_key(1);
        press_key(5);
        press(0);
        repeat (2) @(negedge clk);
        checks++;
        if (tv !== 12'h015 || power !== 4'd5 || state !== 3'd2) begin
            failures++;
            $display("FAIL ar_pre: t=%h pw=%0d st=%0d expected 015 5 2", tv, power, state);
        end
        #2;
        clear = 1'b0;
        #1;
        checks++;
        if (state !== 3'd0 || tv !== 12'h000 || power !== 4'd10
            || magnetron !== 1'b0 || beep !== 1'b0) begin
            failures++;
            $display("FAIL ar_async: st=%0d t=%h pw=%0d mag=%b bp=%b expected 0 000 10 0 0",
                     state, tv, power, magnetron, beep);
        end
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        press_key(4);
        checks++;
        if (tv !== 12'h004 || state !== 3'd1) begin
            failures++;
            $display("FAIL ar_resume: got %h st=%0d expected 004 1", tv, state);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_debounce();
        test_entry();
        test_countdown();
        test_tens_over_five();
        test_door();
        test_power_duty();
        test_priority();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/microwave_ctrl_gen.md
# microwave_ctrl_gen

Parametrised next-generation microwave controller: one synchronous FSM that takes debounced keypad entry with left-shift digit entry, counts a BCD MM:SS time down from a prescaled 1 Hz tick, and drives the magnetron with a selectable power duty cycle and a door interlock. It emits an end-of-cook beep. It replaces the separate encoder, timer and control blocks with a single clocked unit. BCD digit outputs feed the existing seven-segment decoder.

## Interface
- CLK_DIV, 100: clk cycles per 1 s tick; must be ≥2.
- DEBOUNCE, 4: cycles a nonzero key vector must stay stable before it is accepted; must be ≥1.
- MIN_DIGITS, 1: number of BCD minute digits, 1..3.
- BEEP_SEC, 3: beep duration in ticks, 1..15.
- clk  in  1  system clock; all state updates on posedge.
- clear  in  1  asynchronous, active-low reset.
- keys  in  10  keypad, bit i = digit i; if several bits are set, the highest index wins.
- start, stop, cancel, power_key  in  1  active-high buttons; each acts on its rising edge, one action per press.
- door_closed  in  1  level input, 1 = closed.
- minutes  out  4*MIN_DIGITS  BCD minute digits, least significant digit in bits [3:0].
- tens_sec, units_sec  out  4 each  BCD seconds digits.
- power  out  4  power level, 1..10.
- magnetron  out  1  heating enable.
- beep  out  1  end-of-cook tone enable.
- state  out  3  IDLE=0, SETTING=1, COOKING=2, PAUSED=3, DONE=4.

## Operation
- Reset (clear low, asynchronous): state=IDLE, all digits=0, power=10, magnetron=0, beep=0; prescaler, phase, debounce and edge registers are cleared.
- Key path:
  - A nonzero keys vector that is unchanged for DEBOUNCE consecutive cycles is accepted once.
  - After acceptance, keys must return to all-zero before another key can be accepted.
- Digit entry (accepted in IDLE and SETTING only): all digits shift left by one; the new digit enters units_sec; the top minute digit is discarded; state becomes SETTING.
- Entering 9,0 gives 0:90. Tens values above 5 are legal and count down normally.
- power_key (IDLE and SETTING only): power steps 10→9→…→1→10.
- FSM, priority when events coincide is cancel > door open > stop > start > key:
  - IDLE: key → SETTING. start is ignored.
  - SETTING: start with door_closed and time≠0 → COOKING; phase and prescaler are cleared on entry. start with door open or time=0 is ignored. cancel → IDLE and clears the digits.
  - COOKING:
    - On each tick, decrement the time: units borrow from tens; tens 0 reloads to 5 and borrows from minutes.
    - A decrement that reaches all-zero → DONE.
    - door open or stop → PAUSED.
    - cancel → IDLE, digits cleared, power=10.
    - keys and power_key are ignored.
  - PAUSED: start with door_closed → COOKING; prescaler is cleared, phase is held. stop or cancel → IDLE, digits cleared. keys are ignored.
  - DONE: beep=1 for BEEP_SEC ticks, then → IDLE. Any key, start, stop, cancel or door open ends the beep early and goes → IDLE.
- Power duty:
  - A phase counter runs 0..9 and advances on each tick in COOKING.
  - magnetron = (state==COOKING) & (phase < power) & door_closed.
  - The door term is combinational, so opening the door drops magnetron in the same cycle.
  - Power 10 means continuous heating.
- The digit outputs are registered and always show the current time.

## Timing
- Tick: a prescaler counts 0..CLK_DIV-1 in COOKING and DONE only; a tick fires in the cycle when the prescaler equals CLK_DIV-1. The first decrement after start therefore comes CLK_DIV cycles after the start edge is registered.
- Button edges: button inputs are registered once and the rising edge is taken from that register. State changes one cycle after the button input rises.
- Key acceptance: the digit shift appears DEBOUNCE+1 cycles after keys becomes stable.
- The decrement to zero and the move to DONE happen on the same clock edge. beep rises together with state=DONE.
- Assertion of clear in any state forces the reset values immediately. Operation resumes on the first posedge after clear is released.

## Test plan
- Entry shift: MIN_DIGITS=1; press keys 1, 3, 0, 5 → digits 1, 13, 1:30, then 3:05, with the leading 1 dropped; state=SETTING.
- Countdown/borrow: CLK_DIV=4; set 1:00, start with door closed → after 4 cycles 0:59, after 8 cycles 0:58. At 0:00 state=DONE, beep high for 3 ticks (12 cycles), then IDLE.
- Door interlock: open the door mid-cook at 0:42 → magnetron low in the same cycle, state=PAUSED, time frozen. Close the door and press start → resumes counting from 0:42.
- Power duty: power_key pressed 3 times (power=7), cook 0:20 → magnetron high for ticks 0-6 and low for ticks 7-9 of each 10-tick window.
- Priority/ignore: cancel and stop in the same cycle while COOKING → IDLE with digits 0. start with time 0:00 → stays IDLE. Multiple keys {2,7} → digit 7.
- Async reset: assert clear mid-count at 0:15 with power=5 → all outputs go to reset values without a clock edge; power=10.
